// File: rtl/vga_line_sequencer_pkg.sv
// vga_line_sequencer_pkg: phase encoding, default horizontal timing and length helpers.
package vga_line_sequencer_pkg;
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  function automatic logic [10:0] clamp_len(input logic [10:0] v);
    return (v == 11'd0) ? 11'd1 : v;
  endfunction
endpackage

// File: rtl/vga_line_sequencer_cmp.sv
// Comparator11: 11-bit equality comparator used for phase terminal detection.
module Comparator11 (
  input  logic [10:0] i_a,
  input  logic [10:0] i_b,
  output logic        o_eq
);
  assign o_eq = (i_a == i_b);
endmodule

// File: rtl/vga_line_sequencer.sv
// vga_line_sequencer: horizontal VGA phase sequencer with hsync/de/line_end decode.
// Define VGA_SEQ_CFG_EN to build the runtime length-reconfiguration handshake.
module vga_line_sequencer
  import vga_line_sequencer_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [10:0] cfg_active,
  input  logic [10:0] cfg_fp,
  input  logic [10:0] cfg_sync,
  input  logic [10:0] cfg_bp,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic [10:0] pix_cnt,
  output logic [1:0]  phase,
  output logic        hsync,
  output logic        de,
  output logic        line_end
);
  localparam logic [10:0] L_ACTIVE = 11'(H_ACTIVE);
  localparam logic [10:0] L_FP     = 11'(H_FP);
  localparam logic [10:0] L_SYNC   = 11'(H_SYNC);
  localparam logic [10:0] L_BP     = 11'(H_BP);
  phase_t      r_phase, w_phase_nxt;
  logic [10:0] r_pix, w_pix_nxt;
  logic [10:0] r_len_a, r_len_f, r_len_s, r_len_b;
  logic [10:0] w_len, w_last;
  logic        w_match;
  always_comb begin
    w_len  = (r_phase == PH_ACTIVE) ? r_len_a :
             (r_phase == PH_FRONT)  ? r_len_f :
             (r_phase == PH_SYNC)   ? r_len_s : r_len_b;
    w_last = w_len - 11'd1;
  end
  Comparator11 u_cmp (
    .i_a  (r_pix),
    .i_b  (w_last),
    .o_eq (w_match)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_phase <= PH_ACTIVE;
      r_pix   <= 11'd0;
    end else begin
      r_phase <= w_phase_nxt;
      r_pix   <= w_pix_nxt;
    end
  always_comb begin
    w_phase_nxt = (en && w_match) ? phase_t'(r_phase + 2'd1) : r_phase;
    w_pix_nxt   = !en ? r_pix : w_match ? 11'd0 : r_pix + 11'd1;
  end
  assign pix_cnt  = r_pix;
  assign phase    = r_phase;
  assign de       = !rst && (r_phase == PH_ACTIVE);
  assign hsync    = (r_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign line_end = en && w_match && (r_phase == PH_BACK);
`ifdef VGA_SEQ_CFG_EN
  logic        r_pend;
  logic [10:0] r_pnd_a, r_pnd_f, r_pnd_s, r_pnd_b;
  logic        w_xfer, w_apply;
  assign cfg_ready = !r_pend;
  assign w_xfer    = cfg_valid && !r_pend;
  assign w_apply   = line_end && r_pend;
  // Transfer and apply are mutually exclusive: a transfer needs no pending entry.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pend  <= 1'b0;
      r_pnd_a <= 11'd0;
      r_pnd_f <= 11'd0;
      r_pnd_s <= 11'd0;
      r_pnd_b <= 11'd0;
    end else if (w_xfer) begin
      r_pend  <= 1'b1;
      r_pnd_a <= clamp_len(cfg_active);
      r_pnd_f <= clamp_len(cfg_fp);
      r_pnd_s <= clamp_len(cfg_sync);
      r_pnd_b <= clamp_len(cfg_bp);
    end else if (w_apply) begin
      r_pend  <= 1'b0;
    end
`else
  logic w_unused_cfg;
  assign cfg_ready    = 1'b0;
  assign w_unused_cfg = ^{cfg_active, cfg_fp, cfg_sync, cfg_bp, cfg_valid};
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_len_a <= L_ACTIVE;
      r_len_f <= L_FP;
      r_len_s <= L_SYNC;
      r_len_b <= L_BP;
    end
`ifdef VGA_SEQ_CFG_EN
    else if (w_apply) begin
      r_len_a <= r_pnd_a;
      r_len_f <= r_pnd_f;
      r_len_s <= r_pnd_s;
      r_len_b <= r_pnd_b;
    end
`endif
endmodule

// File: tb/tb_vga_line_sequencer.sv
// tb_vga_line_sequencer: directed bench with a position-within-line model checked every cycle.
module tb_vga_line_sequencer;
`ifdef VGA_SEQ_CFG_EN
  localparam bit CFG_EN = 1'b1;
`else
  localparam bit CFG_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst, en, cfg_valid;
  logic [10:0] cfg_active, cfg_fp, cfg_sync, cfg_bp;
  logic        rdy0, hs0, de0, le0;
  logic [10:0] pix0;
  logic [1:0]  phase0;
  logic        rdy1, hs1, de1, le1;
  logic [10:0] pix1;
  logic [1:0]  phase1;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vga_line_sequencer #(.H_ACTIVE(4), .H_FP(2), .H_SYNC(3), .H_BP(1), .SYNC_POL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en),
    .cfg_active(cfg_active), .cfg_fp(cfg_fp), .cfg_sync(cfg_sync), .cfg_bp(cfg_bp),
    .cfg_valid(cfg_valid), .cfg_ready(rdy0),
    .pix_cnt(pix0), .phase(phase0), .hsync(hs0), .de(de0), .line_end(le0)
  );
  vga_line_sequencer #(.H_ACTIVE(4), .H_FP(2), .H_SYNC(3), .H_BP(1), .SYNC_POL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en),
    .cfg_active(cfg_active), .cfg_fp(cfg_fp), .cfg_sync(cfg_sync), .cfg_bp(cfg_bp),
    .cfg_valid(cfg_valid), .cfg_ready(rdy1),
    .pix_cnt(pix1), .phase(phase1), .hsync(hs1), .de(de1), .line_end(le1)
  );

  // Model: the line is a sequence of m_a+m_f+m_s+m_b positions; m_t is the current one.
  int m_t, m_a, m_f, m_s, m_b, m_pa, m_pf, m_ps, m_pb, e_ph, e_px;
  bit m_pend, m_last, e_de, e_le, e_rdy;
  logic [17:0] exp_v, got_v;

  function automatic int clamp(input logic [10:0] v);
    return (v == 11'd0) ? 1 : int'(v);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_t = 0; m_a = 4; m_f = 2; m_s = 3; m_b = 1; m_pend = 0; m_last = 0;
      e_ph = 0; e_px = 0; e_de = 0; e_le = 0; e_rdy = CFG_EN;
    end else begin
      m_last = (m_t == m_a + m_f + m_s + m_b - 1);
      if (m_t < m_a) begin e_ph = 0; e_px = m_t; end
      else if (m_t < m_a + m_f) begin e_ph = 1; e_px = m_t - m_a; end
      else if (m_t < m_a + m_f + m_s) begin e_ph = 2; e_px = m_t - m_a - m_f; end
      else begin e_ph = 3; e_px = m_t - m_a - m_f - m_s; end
      e_de  = (e_ph == 0);
      e_le  = en && m_last;
      e_rdy = CFG_EN && !m_pend;
    end
    exp_v = {2'(e_ph), 11'(e_px), e_ph != 2, e_ph == 2, e_de, e_le, e_rdy};
    got_v = {phase0, pix0, hs0, hs1, de0, le0, rdy0};
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle @%0t: got {ph,pix,hs0,hs1,de,le,rdy}=%h expected %h", $time, got_v, exp_v);
    end
    if (!rst) begin
      if (CFG_EN && cfg_valid && !m_pend) begin
        m_pend = 1;
        m_pa = clamp(cfg_active); m_pf = clamp(cfg_fp); m_ps = clamp(cfg_sync); m_pb = clamp(cfg_bp);
      end else if (e_le && m_pend) begin
        m_pend = 0;
        m_a = m_pa; m_f = m_pf; m_s = m_ps; m_b = m_pb;
      end
      if (en) m_t = m_last ? 0 : m_t + 1;
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic cyc(input logic e, input logic v);
    @(posedge clk); #1;
    en = e; cfg_valid = v;
    @(negedge clk);
  endtask

  task automatic set_cfg(input int a, input int f, input int s, input int b);
    cfg_active = 11'(a); cfg_fp = 11'(f); cfg_sync = 11'(s); cfg_bp = 11'(b);
  endtask

  task automatic measure_line(output int len, output int fronts);
    len = 0; fronts = 0;
    do begin
      cyc(1'b1, 1'b0);
      len++;
      fronts += int'(phase0 == 2'd1);
    end while (!le0 && len < 64);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int de_cnt, h0_cnt, h1_cnt, le_cnt, l1, l2, l3, rdy_lo, len, fr, n;
    logic [19:0] seq;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; set_cfg(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_phase", phase0, 0);
    chk("reset_pix", pix0, 0);
    chk("reset_de", de0, 0);
    chk("reset_hsync_pol0", hs0, 1);
    chk("reset_hsync_pol1", hs1, 0);
    chk("reset_ready", rdy0, CFG_EN);
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("de_after_release", de0, 1);
    seq = '0; de_cnt = 0; h0_cnt = 0; h1_cnt = 0; le_cnt = 0; l1 = -1;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) cyc(1'b1, 1'b0);
      if (i < 10) seq = {seq[17:0], phase0};
      de_cnt += int'(de0); h0_cnt += int'(!hs0); h1_cnt += int'(hs1); le_cnt += int'(le0);
      if (le0 && l1 < 0) l1 = i;
    end
    chk("phase_sequence", int'(seq), 'h005AB);
    chk("first_line_end", l1, 9);
    chk("line_end_count", le_cnt, 3);
    chk("de_count", de_cnt, 12);
    chk("hsync_pol0_low", h0_cnt, 9);
    chk("hsync_pol1_high", h1_cnt, 9);
    l1 = -1; l2 = -1; le_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(i % 2 == 0, 1'b0);
      if (le0) begin
        le_cnt++;
        if (l1 < 0) l1 = i; else if (l2 < 0) l2 = i;
      end
    end
    chk("toggle_first_le", l1, 18);
    chk("toggle_period", l2 - l1, 20);
    chk("toggle_le_count", le_cnt, 3);
    set_cfg(8, 1, 1, 1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("cfg_ready_mid_active", rdy0, CFG_EN);
    set_cfg(2, 2, 2, 2);
    l1 = -1; l2 = -1; l3 = -1; rdy_lo = 0;
    for (int j = 0; j < 28; j++) begin
      cyc(1'b1, j < 27);
      if (j <= 7 && !rdy0) rdy_lo++;
      if (j == 8) chk("cfg_ready_after_le", rdy0, CFG_EN);
      if (le0) begin
        if (l1 < 0) l1 = j; else if (l2 < 0) l2 = j; else if (l3 < 0) l3 = j;
      end
    end
    chk("cfg_ready_low", rdy_lo, 8);
    chk("cfg_le1", l1, 7);
    chk("cfg_le2", l2, CFG_EN ? 18 : 17);
    chk("cfg_le3", l3, CFG_EN ? 26 : 27);
    set_cfg(3, 0, 2, 1);
    cyc(1'b1, 1'b1);
    measure_line(len, fr);
    measure_line(len, fr);
    chk("fp0_line_len", len, CFG_EN ? 7 : 10);
    chk("fp0_front_cycles", fr, CFG_EN ? 1 : 2);
    set_cfg(5, 5, 5, 5);
    cyc(1'b1, 1'b1);
    n = 0;
    do begin cyc(1'b1, 1'b0); n++; end while (phase0 != 2'd2 && n < 40);
    chk("reached_sync", phase0, 2);
    chk("pending_ready_low", rdy0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_phase", phase0, 0);
    chk("rst_pix", pix0, 0);
    chk("rst_line_end", le0, 0);
    chk("rst_de", de0, 0);
    chk("rst_hsync", hs0, 1);
    chk("rst_ready", rdy0, CFG_EN);
    @(posedge clk); #1;
    rst = 1'b0;
    measure_line(len, fr);
    measure_line(len, fr);
    chk("post_rst_line_len", len, 10);
    chk("post_rst_front", fr, 2);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
